// File: rtl/bcd_pkg.sv
// ----------------------------------------------------------------------------
// bcd_pkg
// Shared definitions for the serial BCD calculator datapath.
//   - FSM state encoding for the sequencer (IDLE, LOAD, ADD, COMP, FIN)
//   - BCD_MAX: the largest legal BCD digit value
//   - nines_comp(digit): 9 - digit, used for subtraction and ten's complement
//   - digit_valid(digit): true when the nibble is a legal BCD digit (0..9)
// ----------------------------------------------------------------------------
package bcd_pkg;

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_LOAD = 3'd1;
    localparam logic [2:0] ST_ADD  = 3'd2;
    localparam logic [2:0] ST_COMP = 3'd3;
    localparam logic [2:0] ST_FIN  = 3'd4;

    localparam logic [3:0] BCD_MAX = 4'd9;

    // Only meaningful for legal digits; callers check digit_valid first.
    function automatic logic [3:0] nines_comp(input logic [3:0] digit);
        return BCD_MAX - digit;
    endfunction

    function automatic logic digit_valid(input logic [3:0] digit);
        return (digit <= BCD_MAX);
    endfunction

endpackage

// File: rtl/bcd_digit_add.sv
// ----------------------------------------------------------------------------
// bcd_digit_add
// Combinational single-digit BCD adder with +6 decimal correction.
// Ports:
//   a, b  in  [3:0]  BCD digits (0..9)
//   cin   in  1      carry in from the previous digit
//   sum   out [3:0]  BCD sum digit
//   cout  out 1      decimal carry out
// ----------------------------------------------------------------------------
module bcd_digit_add
    import bcd_pkg::*;
(
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] sum,
    output logic       cout
);

    logic [4:0] raw;
    logic [3:0] corrected;

    // The binary sum of two legal digits plus carry never exceeds 19, so a
    // single +6 correction (mod 16) lands the low nibble on the right digit
    // whenever the binary sum passes 9.
    always_comb begin
        raw       = {1'b0, a} + {1'b0, b} + {4'b0000, cin};
        corrected = raw[3:0] + 4'd6;
        if (raw > {1'b0, BCD_MAX}) begin
            sum  = corrected;
            cout = 1'b1;
        end else begin
            sum  = raw[3:0];
            cout = 1'b0;
        end
    end

endmodule

// File: rtl/bcd_serial_calc_ctrl.sv
// ----------------------------------------------------------------------------
// bcd_serial_calc_ctrl
// Multi-digit BCD add/subtract sequencer. One shared digit adder is stepped
// through the operands least-significant digit first; negative differences
// get a second pass that forms the ten's complement, so the result is always
// a sign-magnitude BCD value for the 7-segment path.
// Ports:
//   clk     in   1       system clock
//   rst     in   1       synchronous active-high reset
//   start   in   1       request, only looked at while idle
//   op      in   1       0 = a+b, 1 = a-b
//   a, b    in   4*NDIG  packed BCD operands, digit 0 in bits [3:0]
//   busy    out  1       operation in progress
//   done    out  1       one-cycle pulse, result and flags valid
//   result  out  4*NDIG  BCD magnitude, held until the next result
//   neg     out  1       subtraction result is negative
//   ovf     out  1       addition carried out of the top digit
//   err     out  1       an operand digit was above 9, result is 0
// ----------------------------------------------------------------------------
module bcd_serial_calc_ctrl
    import bcd_pkg::*;
#(
    parameter int NDIG = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              op,
    input  logic [4*NDIG-1:0] a,
    input  logic [4*NDIG-1:0] b,
    output logic              busy,
    output logic              done,
    output logic [4*NDIG-1:0] result,
    output logic              neg,
    output logic              ovf,
    output logic              err
);

    localparam int W    = 4 * NDIG;
    localparam int IDXW = $clog2(NDIG) + 1;

    logic [2:0]      state;
    logic [W-1:0]    a_q;
    logic [W-1:0]    b_q;
    logic [W-1:0]    work_q;
    logic [W-1:0]    work_next;
    logic [W-1:0]    b_nines;
    logic            op_q;
    logic            carry;
    logic [IDXW-1:0] idx;
    logic            last_digit;
    logic            operands_ok;

    logic [3:0]      a_dig;
    logic [3:0]      b_dig;
    logic [3:0]      w_dig;
    logic [3:0]      add_a;
    logic [3:0]      add_b;
    logic [3:0]      add_sum;
    logic            add_cin;
    logic            add_cout;

    // Operand screening and the nines-complemented addend, both derived
    // from the latched operands so they are stable through LOAD.
    always_comb begin
        operands_ok = 1'b1;
        b_nines     = '0;
        for (int i = 0; i < NDIG; i++) begin
            if (!digit_valid(a_q[4*i +: 4]) || !digit_valid(b_q[4*i +: 4]))
                operands_ok = 1'b0;
            b_nines[4*i +: 4] = nines_comp(b_q[4*i +: 4]);
        end
    end

    // Pick out the current digit of each register and build the working
    // register with the adder's sum dropped into the current slot.
    always_comb begin
        a_dig     = '0;
        b_dig     = '0;
        w_dig     = '0;
        work_next = work_q;
        for (int i = 0; i < NDIG; i++) begin
            if (idx == IDXW'(i)) begin
                a_dig                = a_q[4*i +: 4];
                b_dig                = b_q[4*i +: 4];
                w_dig                = work_q[4*i +: 4];
                work_next[4*i +: 4]  = add_sum;
            end
        end
    end

    // The complement pass feeds 9-w through the adder with a zero addend;
    // the carry register already holds the +1 for digit 0.
    always_comb begin
        if (state == ST_COMP) begin
            add_a = nines_comp(w_dig);
            add_b = 4'd0;
        end else begin
            add_a = a_dig;
            add_b = b_dig;
        end
        add_cin = carry;
    end

    assign last_digit = (idx == IDXW'(NDIG - 1));

    bcd_digit_add u_digit_add (
        .a    (add_a),
        .b    (add_b),
        .cin  (add_cin),
        .sum  (add_sum),
        .cout (add_cout)
    );

    // Sequencer. The result register is written on the edge that enters FIN
    // so that result and flags are already valid while done is high.
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= ST_IDLE;
            a_q    <= '0;
            b_q    <= '0;
            work_q <= '0;
            op_q   <= 1'b0;
            carry  <= 1'b0;
            idx    <= '0;
            result <= '0;
            neg    <= 1'b0;
            ovf    <= 1'b0;
            err    <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        a_q   <= a;
                        b_q   <= b;
                        op_q  <= op;
                        state <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    neg    <= 1'b0;
                    ovf    <= 1'b0;
                    err    <= 1'b0;
                    idx    <= '0;
                    work_q <= '0;
                    if (!operands_ok) begin
                        err    <= 1'b1;
                        result <= '0;
                        state  <= ST_FIN;
                    end else begin
                        carry <= op_q;
                        if (op_q)
                            b_q <= b_nines;
                        state <= ST_ADD;
                    end
                end
                ST_ADD: begin
                    work_q <= work_next;
                    carry  <= add_cout;
                    idx    <= idx + IDXW'(1);
                    if (last_digit) begin
                        if (!op_q) begin
                            ovf    <= add_cout;
                            result <= work_next;
                            state  <= ST_FIN;
                        end else if (add_cout) begin
                            result <= work_next;
                            state  <= ST_FIN;
                        end else begin
                            // No end-around carry means b > a: the sum is
                            // the complement of the magnitude.
                            neg   <= 1'b1;
                            idx   <= '0;
                            carry <= 1'b1;
                            state <= ST_COMP;
                        end
                    end
                end
                ST_COMP: begin
                    work_q <= work_next;
                    carry  <= add_cout;
                    idx    <= idx + IDXW'(1);
                    if (last_digit) begin
                        result <= work_next;
                        state  <= ST_FIN;
                    end
                end
                ST_FIN: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy = (state == ST_LOAD) || (state == ST_ADD) || (state == ST_COMP);
    assign done = (state == ST_FIN);

endmodule

// File: tb/tb_bcd_serial_calc_ctrl.sv
// ----------------------------------------------------------------------------
// tb_bcd_serial_calc_ctrl
// Directed bench for the serial BCD calculator with NDIG=2. A table of
// operand/operator records with hand-computed results is applied in a loop,
// followed by hand-written sequences for start-while-busy and mid-operation
// reset.
// ----------------------------------------------------------------------------
module tb_bcd_serial_calc_ctrl;

    localparam int NDIG = 2;
    localparam int W    = 4 * NDIG;
    localparam int MAX_WAIT = 50;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic         op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         busy;
    logic         done;
    logic [W-1:0] result;
    logic         neg;
    logic         ovf;
    logic         err;

    int testsRun    = 0;
    int testsFailed = 0;

    typedef struct {
        string        name;
        logic         op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] expResult;
        logic         expNeg;
        logic         expOvf;
        logic         expErr;
        int           expLatency;
    } vec_t;

    localparam int NVEC = 11;
    vec_t vecs [NVEC];

    bcd_serial_calc_ctrl #(.NDIG(NDIG)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .op     (op),
        .a      (a),
        .b      (b),
        .busy   (busy),
        .done   (done),
        .result (result),
        .neg    (neg),
        .ovf    (ovf),
        .err    (err)
    );

    // Free-running clock, outputs are sampled on the falling edge.
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        testsRun++;
        if (actual !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    // Pulse start for one cycle and count cycles from the accepting edge
    // until done is seen; returns MAX_WAIT if done never shows up.
    task automatic applyStimulus(input logic opIn, input logic [W-1:0] aIn,
                                 input logic [W-1:0] bIn, output int latency);
        @(negedge clk);
        a     = aIn;
        b     = bIn;
        op    = opIn;
        start = 1'b1;
        @(negedge clk);
        start   = 1'b0;
        latency = 1;
        while (!done && latency < MAX_WAIT) begin
            @(negedge clk);
            latency++;
        end
    endtask

    task automatic runVector(input vec_t v);
        int lat;
        applyStimulus(v.op, v.a, v.b, lat);
        checkOutput({v.name, " latency"}, 32'(lat), 32'(v.expLatency));
        checkOutput({v.name, " result"}, 32'(result), 32'(v.expResult));
        checkOutput({v.name, " neg"}, 32'(neg), 32'(v.expNeg));
        checkOutput({v.name, " ovf"}, 32'(ovf), 32'(v.expOvf));
        checkOutput({v.name, " err"}, 32'(err), 32'(v.expErr));
        @(negedge clk);
        checkOutput({v.name, " done width"}, 32'(done), 32'(0));
    endtask

    initial begin
        logic [10:0] busyObs;
        logic [10:0] doneObs;
        int          doneSeen;
        vec_t        extra;

        vecs[0]  = '{"add 45+38", 1'b0, 8'h45, 8'h38, 8'h83, 1'b0, 1'b0, 1'b0, 4};
        vecs[1]  = '{"add 99+01", 1'b0, 8'h99, 8'h01, 8'h00, 1'b0, 1'b1, 1'b0, 4};
        vecs[2]  = '{"add 09+09", 1'b0, 8'h09, 8'h09, 8'h18, 1'b0, 1'b0, 1'b0, 4};
        vecs[3]  = '{"sub 52-17", 1'b1, 8'h52, 8'h17, 8'h35, 1'b0, 1'b0, 1'b0, 4};
        vecs[4]  = '{"sub 40-40", 1'b1, 8'h40, 8'h40, 8'h00, 1'b0, 1'b0, 1'b0, 4};
        vecs[5]  = '{"err a=A5",  1'b0, 8'hA5, 8'h11, 8'h00, 1'b0, 1'b0, 1'b1, 2};
        vecs[6]  = '{"sub 17-52", 1'b1, 8'h17, 8'h52, 8'h35, 1'b1, 1'b0, 1'b0, 6};
        vecs[7]  = '{"err b=3C",  1'b1, 8'h12, 8'h3C, 8'h00, 1'b0, 1'b0, 1'b1, 2};
        vecs[8]  = '{"add 50+50", 1'b0, 8'h50, 8'h50, 8'h00, 1'b0, 1'b1, 1'b0, 4};
        vecs[9]  = '{"sub 99-99", 1'b1, 8'h99, 8'h99, 8'h00, 1'b0, 1'b0, 1'b0, 4};
        vecs[10] = '{"sub 00-01", 1'b1, 8'h00, 8'h01, 8'h01, 1'b1, 1'b0, 1'b0, 6};

        rst   = 1'b1;
        start = 1'b0;
        op    = 1'b0;
        a     = '0;
        b     = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checkOutput("reset busy",   32'(busy),   32'(0));
        checkOutput("reset done",   32'(done),   32'(0));
        checkOutput("reset result", 32'(result), 32'(0));
        checkOutput("reset neg",    32'(neg),    32'(0));
        checkOutput("reset ovf",    32'(ovf),    32'(0));
        checkOutput("reset err",    32'(err),    32'(0));

        // 45+38 with start held into the cycle after acceptance: the second
        // request lands in LOAD and must not produce a second done.
        busyObs = '0;
        doneObs = '0;
        @(negedge clk);
        a     = 8'h45;
        b     = 8'h38;
        op    = 1'b0;
        start = 1'b1;
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            if (c == 2)
                start = 1'b0;
            busyObs[c] = busy;
            doneObs[c] = done;
            if (c == 4)
                checkOutput("busy-start result", 32'(result), 32'h83);
        end
        checkOutput("busy profile", 32'(busyObs), 32'(11'b00000001110));
        checkOutput("done profile", 32'(doneObs), 32'(11'b00000010000));

        for (int i = 0; i < NVEC; i++)
            runVector(vecs[i]);

        // Reset two cycles into a negative subtraction: nothing completes,
        // all outputs fall back to zero, and the next request works normally.
        @(negedge clk);
        a     = 8'h17;
        b     = 8'h52;
        op    = 1'b1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        rst   = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checkOutput("abort busy",   32'(busy),   32'(0));
        checkOutput("abort done",   32'(done),   32'(0));
        checkOutput("abort result", 32'(result), 32'(0));
        checkOutput("abort neg",    32'(neg),    32'(0));
        checkOutput("abort ovf",    32'(ovf),    32'(0));
        checkOutput("abort err",    32'(err),    32'(0));
        doneSeen = 0;
        repeat (8) begin
            @(negedge clk);
            if (done)
                doneSeen++;
        end
        checkOutput("abort no done", 32'(doneSeen), 32'(0));

        extra = '{"post-abort 23+11", 1'b0, 8'h23, 8'h11, 8'h34, 1'b0, 1'b0, 1'b0, 4};
        runVector(extra);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
